// File: rtl/counter_cmd_ctrl_pkg.sv
// Shared encodings for the counter command sequencer: command codes, FSM states and
// the button priority helper.
package counter_ctrl_defs;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_INC   = 2'b01,
        CMD_LOAD  = 2'b10,
        CMD_RESET = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DEBOUNCE = 2'b01,
        ISSUE    = 2'b10,
        RELEASE  = 2'b11
    } state_e;

    // Highest-priority pressed button wins: reset > load > inc.
    function automatic cmd_e pick_cmd(input logic b_reset, input logic b_load,
                                      input logic b_inc);
        if (b_reset) begin
            return CMD_RESET;
        end else if (b_load) begin
            return CMD_LOAD;
        end else if (b_inc) begin
            return CMD_INC;
        end
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for raw button levels; clears to 0 on reset.
module sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Turns bouncing buttons plus an auto-run request into clean, mutually exclusive,
// single-cycle reset/load/increment commands for counter16.
module counter_cmd_ctrl
    import counter_ctrl_defs::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned TICK_DIV        = 12000000,
    parameter int unsigned TIMER_W         = 24
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_reset,
    input  logic       btn_load,
    input  logic       btn_inc,
    input  logic       auto_run,
    output logic       cnt_reset,
    output logic       cnt_load,
    output logic       cnt_increment,
    output logic       busy,
    output logic [1:0] last_cmd
);

    localparam logic [TIMER_W-1:0] DebLast  = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TickLast = TIMER_W'(TICK_DIV - 1);
    localparam logic [TIMER_W-1:0] TimerOne = TIMER_W'(1);

    logic s_reset, s_load, s_inc;

    sync_2ff u_sync_reset (.clock(clock), .reset_n(reset_n), .d(btn_reset), .q(s_reset));
    sync_2ff u_sync_load  (.clock(clock), .reset_n(reset_n), .d(btn_load),  .q(s_load));
    sync_2ff u_sync_inc   (.clock(clock), .reset_n(reset_n), .d(btn_inc),   .q(s_inc));

    state_e             state_q, state_d;
    cmd_e               cmd_q, cmd_d, last_q, last_d;
    logic [TIMER_W-1:0] timer_q, timer_d, tick_q, tick_d;
    logic               reset_q, reset_d, load_q, load_d, inc_q, inc_d, busy_q, busy_d;
    logic               any_btn, latched_btn, tick_wrap, tick_fire;

    assign any_btn   = s_reset | s_load | s_inc;
    assign tick_wrap = auto_run && (tick_q == TickLast);
    // Ticks are only honoured in IDLE with no button; otherwise they are dropped.
    assign tick_fire = tick_wrap && (state_q == IDLE) && !any_btn;

    always_comb begin
        latched_btn = 1'b0;
        case (cmd_q)
            CMD_RESET: latched_btn = s_reset;
            CMD_LOAD:  latched_btn = s_load;
            CMD_INC:   latched_btn = s_inc;
            default:   latched_btn = 1'b0;
        endcase
    end

    always_comb begin
        tick_d = '0;
        if (auto_run && !tick_wrap) begin
            tick_d = tick_q + TimerOne;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (any_btn) begin
                    cmd_d   = pick_cmd(s_reset, s_load, s_inc);
                    timer_d = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!latched_btn) begin
                    state_d = IDLE;
                end else if (timer_q == DebLast) begin
                    state_d = ISSUE;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (any_btn) begin
                    timer_d = '0;
                end else if (timer_q == DebLast) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reset_d = 1'b0;
        load_d  = 1'b0;
        inc_d   = 1'b0;
        last_d  = last_q;
        busy_d  = (state_d != IDLE);
        if (state_d == ISSUE) begin
            last_d = cmd_q;
            case (cmd_q)
                CMD_RESET: reset_d = 1'b1;
                CMD_LOAD:  load_d  = 1'b1;
                CMD_INC:   inc_d   = 1'b1;
                default:   last_d  = last_q;
            endcase
        end else if (tick_fire) begin
            inc_d  = 1'b1;
            last_d = CMD_INC;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cmd_q   <= CMD_NONE;
            last_q  <= CMD_NONE;
            timer_q <= '0;
            tick_q  <= '0;
            reset_q <= 1'b0;
            load_q  <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            tick_q  <= tick_d;
            reset_q <= reset_d;
            load_q  <= load_d;
            inc_q   <= inc_d;
            busy_q  <= busy_d;
        end
    end

    assign cnt_reset     = reset_q;
    assign cnt_load      = load_q;
    assign cnt_increment = inc_q;
    assign busy          = busy_q;
    assign last_cmd      = last_q;

endmodule
